// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, debounce filter, and
// press/release/long-press/auto-repeat pulse generation per independent channel.
module key_debounce_multi #(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter bit REPEAT_EN   = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int DB_CYC   = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYC = CLK_FREQ_HZ / 1000 * LONG_MS;
  localparam int REP_CYC  = CLK_FREQ_HZ / 1000 * REPEAT_MS;
  localparam int HOLD_MAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int DB_W     = $clog2(DB_CYC) + 1;
  localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [HOLD_W-1:0]   LONG_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0]   REP_LAST  = HOLD_W'(REP_CYC - 1);
  localparam logic [NUM_KEYS-1:0] REL_LVL   = {NUM_KEYS{ACTIVE_LOW}};

  if (DB_CYC < 2 || REP_CYC < 1) begin : g_bad_params
    $error("key_debounce_multi: DB_CYC must be >= 2 and REP_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, FILT_DN, DOWN, FILT_UP} state_t;

  logic [NUM_KEYS-1:0] s1_q, s2_q, lv;

  // Synchronisers reset to the released level so no press appears out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= REL_LVL;
      s2_q <= REL_LVL;
    end else begin
      s1_q <= key_in;
      s2_q <= s1_q;
    end
  end

  assign lv = s2_q ^ REL_LVL;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    state_t            st_q;
    logic [DB_W-1:0]   db_q;
    logic [HOLD_W-1:0] hold_q, hold_nxt;
    logic              long_done_q, long_fire, rep_fire;
    logic              state_q, press_q, rel_q, long_q, rep_q;

    // Hold timer: counts to the long-press point once, then wraps at the repeat period.
    always_comb begin
      hold_nxt  = hold_q;
      long_fire = 1'b0;
      rep_fire  = 1'b0;
      if (!long_done_q) begin
        if (hold_q == LONG_LAST) begin
          long_fire = 1'b1;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_q + 1'b1;
        end
      end else if (REPEAT_EN) begin
        if (hold_q == REP_LAST) begin
          rep_fire = 1'b1;
          hold_nxt = '0;
        end else begin
          hold_nxt = hold_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q        <= IDLE;
        db_q        <= '0;
        hold_q      <= '0;
        long_done_q <= 1'b0;
        state_q     <= 1'b0;
        press_q     <= 1'b0;
        rel_q       <= 1'b0;
        long_q      <= 1'b0;
        rep_q       <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
        case (st_q)
          IDLE: begin
            db_q   <= '0;
            hold_q <= '0;
            if (lv[g]) st_q <= FILT_DN;
          end
          FILT_DN: begin
            if (!lv[g]) begin
              st_q <= IDLE;
              db_q <= '0;
            end else if (db_q == DB_LAST) begin
              st_q        <= DOWN;
              db_q        <= '0;
              hold_q      <= '0;
              long_done_q <= 1'b0;
              press_q     <= 1'b1;
              state_q     <= 1'b1;
            end else begin
              db_q <= db_q + 1'b1;
            end
          end
          DOWN: begin
            hold_q      <= hold_nxt;
            long_done_q <= long_done_q | long_fire;
            long_q      <= long_fire;
            rep_q       <= rep_fire;
            db_q        <= '0;
            if (!lv[g]) st_q <= FILT_UP;
          end
          FILT_UP: begin
            // An accepted release suppresses any long/repeat pulse due on the same edge.
            if (!lv[g] && db_q == DB_LAST) begin
              st_q        <= IDLE;
              db_q        <= '0;
              hold_q      <= '0;
              long_done_q <= 1'b0;
              rel_q       <= 1'b1;
              state_q     <= 1'b0;
            end else begin
              hold_q      <= hold_nxt;
              long_done_q <= long_done_q | long_fire;
              long_q      <= long_fire;
              rep_q       <= rep_fire;
              if (lv[g]) begin
                st_q <= DOWN;
                db_q <= '0;
              end else begin
                db_q <= db_q + 1'b1;
              end
            end
          end
          default: begin
            st_q        <= IDLE;
            db_q        <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            state_q     <= 1'b0;
          end
        endcase
      end
    end

    assign key_state[g]   = state_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = rel_q;
    assign key_long[g]    = long_q;
    assign key_repeat[g]  = rep_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: two instances (repeat on / off) share stimulus.
module tb_key_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_in;
  logic [1:0] st_a, pr_a, rl_a, lg_a, rp_a;
  logic [1:0] st_b, pr_b, rl_b, lg_b, rp_b;

  int tests = 0;
  int fails = 0;
  int n_press = 0, n_rel = 0, n_long_a = 0, n_rep_a = 0, n_long_b = 0, n_rep_b = 0;
  int b_press, b_rel, b_long_a, b_rep_a, b_long_b, b_rep_b;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .NUM_KEYS(2), .CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(1), .LONG_MS(5),
    .REPEAT_MS(2), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .key_in(key_in), .key_state(st_a), .key_press(pr_a),
    .key_release(rl_a), .key_long(lg_a), .key_repeat(rp_a)
  );

  key_debounce_multi #(
    .NUM_KEYS(2), .CLK_FREQ_HZ(10_000), .DEBOUNCE_MS(1), .LONG_MS(5),
    .REPEAT_MS(2), .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .key_in(key_in), .key_state(st_b), .key_press(pr_b),
    .key_release(rl_b), .key_long(lg_b), .key_repeat(rp_b)
  );

  always @(negedge clk) begin
    if (pr_a[0]) n_press++;
    if (rl_a[0]) n_rel++;
    if (lg_a[0]) n_long_a++;
    if (rp_a[0]) n_rep_a++;
    if (lg_b[0]) n_long_b++;
    if (rp_b[0]) n_rep_b++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_press = n_press; b_rel = n_rel; b_long_a = n_long_a;
    b_rep_a = n_rep_a; b_long_b = n_long_b; b_rep_b = n_rep_b;
  endtask

  initial begin
    rst    = 1'b0;
    key_in = 2'b11;
    tick(3);
    chk("reset_outs_a", {st_a, pr_a, rl_a, lg_a, rp_a}, 0);
    chk("reset_outs_b", {st_b, pr_b, rl_b, lg_b, rp_b}, 0);
    rst = 1'b1;
    tick(15);
    chk("post_reset_no_press", {st_a, pr_a}, 0);

    // Clean press on key 0, short hold, release
    snap();
    key_in = 2'b10;
    tick(12);
    chk("press_early", pr_a, 2'b00);
    tick(1);
    chk("press_pulse", pr_a, 2'b01);
    chk("press_state", st_a, 2'b01);
    tick(1);
    chk("press_1cyc", pr_a, 2'b00);
    chk("state_held", st_a, 2'b01);
    tick(29);
    key_in = 2'b11;
    tick(12);
    chk("rel_early", rl_a, 2'b00);
    tick(1);
    chk("rel_pulse", rl_a, 2'b01);
    chk("rel_state", st_a, 2'b00);
    tick(1);
    chk("rel_1cyc", rl_a, 2'b00);
    chk("ch1_quiet", {st_a[1], n_press - b_press}, 1);
    chk("short_no_long_rep", n_long_a - b_long_a + n_rep_a - b_rep_a, 0);

    // Bounce while released
    snap();
    key_in = 2'b10; tick(6);
    key_in = 2'b11; tick(3);
    key_in = 2'b10; tick(5);
    key_in = 2'b11; tick(20);
    chk("bounce_no_press", n_press - b_press, 0);
    chk("bounce_state0", st_a, 2'b00);

    // Bounce while held
    key_in = 2'b10;
    tick(13);
    chk("held_press", pr_a, 2'b01);
    snap();
    key_in = 2'b11; tick(6);
    key_in = 2'b10; tick(3);
    key_in = 2'b11; tick(5);
    key_in = 2'b10; tick(15);
    chk("bounce_no_rel", n_rel - b_rel, 0);
    chk("bounce_state1", st_a, 2'b01);
    key_in = 2'b11;
    tick(13);
    chk("bounce_then_rel", rl_a, 2'b01);
    chk("bounce_no_long", n_long_a - b_long_a, 0);
    tick(5);

    // Long press with repeat; release timed to collide with a due repeat
    key_in = 2'b10;
    tick(13);
    chk("lp_press", pr_a, 2'b01);
    snap();
    tick(49);
    chk("long_early", {lg_a, lg_b}, 0);
    tick(1);
    chk("long_a", lg_a, 2'b01);
    chk("long_b", lg_b, 2'b01);
    tick(1);
    chk("long_1cyc", {lg_a, lg_b}, 0);
    tick(18);
    chk("rep_early", rp_a, 2'b00);
    tick(1);
    chk("rep_first", rp_a, 2'b01);
    chk("rep_off_b", rp_b, 2'b00);
    tick(80);
    chk("rep_150", rp_a, 2'b01);
    tick(7);
    key_in = 2'b11;
    tick(13);
    chk("rel_wins_rel", rl_a, 2'b01);
    chk("rel_wins_rep", rp_a, 2'b00);
    tick(40);
    chk("lp_rep_count", n_rep_a - b_rep_a, 5);
    chk("lp_long_count", n_long_a - b_long_a, 1);
    chk("lp_b_long_count", n_long_b - b_long_b, 1);
    chk("lp_b_rep_count", n_rep_b - b_rep_b, 0);
    chk("lp_rel_count", n_rel - b_rel, 1);

    // Reset while held past the long press
    key_in = 2'b10;
    tick(13);
    chk("rst_press", pr_a, 2'b01);
    tick(55);
    chk("rst_pre_state", st_a, 2'b01);
    snap();
    rst = 1'b0;
    #1;
    chk("rst_async_a", {st_a, pr_a, rl_a, lg_a, rp_a}, 0);
    chk("rst_async_b", {st_b, pr_b, rl_b, lg_b, rp_b}, 0);
    tick(3);
    rst = 1'b1;
    tick(12);
    chk("rst_repress_early", pr_a, 2'b00);
    tick(1);
    chk("rst_repress", pr_a, 2'b01);
    chk("rst_no_rel", n_rel - b_rel, 0);
    tick(49);
    chk("rst_long_early", lg_a, 2'b00);
    tick(1);
    chk("rst_long", lg_a, 2'b01);
    key_in = 2'b11;
    tick(20);

    // Simultaneous channels
    key_in = 2'b00;
    tick(13);
    chk("sim_press", pr_a, 2'b11);
    chk("sim_state", st_a, 2'b11);
    tick(5);
    key_in = 2'b11;
    tick(13);
    chk("sim_rel", rl_a, 2'b11);
    chk("sim_state0", st_a, 2'b00);
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
